desc_win_seq: RTL
=================

# desc_win_seq

Sequencer for the descriptor sampling window. On a keypoint start it walks all 256 positions of the 16×16 window. For each position it drives the address and orientation-bank select into the combinational direction ROM bank (the dirNN_x/dirNN_y family), and registers the returned signed 5-bit x/y offsets. It presents them downstream as a valid/ready stream. It sits between keypoint orientation assignment and the descriptor histogram accumulator.

## Interface
Parameters:
- N_DIR, 36: number of orientation bins / ROM banks.
- ADDR_W, 8: window address width (row = a[7:4], col = a[3:0]).
- OFS_W, 5: ROM offset width, two's complement.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a window sweep; sampled only in IDLE.
- dir  in  6  orientation bin, latched on an accepted start.
- busy  out  1  high from accepted start until the final sample is accepted.
- err  out  1  one-cycle pulse when start is rejected because dir ≥ N_DIR.
- rom_sel  out  6  ROM bank select, equal to the latched dir.
- rom_a  out  ADDR_W  ROM address, equal to the current window counter.
- rom_dx  in  OFS_W  x offset returned combinationally by the ROM.
- rom_dy  in  OFS_W  y offset returned combinationally by the ROM.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_dx  out  OFS_W  registered x offset.
- out_dy  out  OFS_W  registered y offset.
- out_idx  out  ADDR_W  window index of the presented sample.
- out_last  out  1  high with out_idx == 255.
- done  out  1  one-cycle pulse after the last sample is accepted.

## Operation
- States are IDLE, RUN and DRAIN.
- **IDLE:**
  - On start with dir < N_DIR: latch dir, clear the counter, go to RUN, set busy.
  - On start with dir ≥ N_DIR: pulse err, stay in IDLE.
  - Start without a valid dir does nothing further.
- **RUN:**
  - Load condition: load = !out_valid || out_ready.
  - On load: capture rom_dx, rom_dy and the counter into the output register, set out_valid, and increment the counter.
  - When the counter value 255 is loaded, go to DRAIN. The counter is not incremented past 255 (no wrap).
- **DRAIN:**
  - Hold the final sample until out_ready.
  - On acceptance: clear out_valid, clear busy, pulse done next cycle, go to IDLE.
- start while busy is ignored. dir changes while busy have no effect.
- out_* holds stable while out_valid && !out_ready.
- rom_sel and rom_a are combinational from registers, stable for the whole cycle.
- Offsets pass through unmodified. No sign extension or arithmetic is applied in this block.
- **Reset (any state, including mid-sweep):**
  - State IDLE, counter 0.
  - busy, err, done, out_valid, out_last all 0.
  - out_dx, out_dy, out_idx 0; rom_sel 0, rom_a 0.
  - A sweep interrupted by reset is abandoned; no done is produced.

## Timing
- Accepted start at edge T0 → busy=1 after T0; rom_a=0 during cycle T0..T1.
- First out_valid after T1 (1-cycle latency from busy).
- With out_ready held high: one sample per cycle.
  - Sample k is presented after edge T1+k.
  - The final sample (idx 255) is presented after T256 and accepted at T257.
  - busy falls after T257; the done pulse follows the last acceptance edge by one cycle.
- A sweep occupies 258 cycles from start to done.
- Back-to-back sweeps: start is accepted in the cycle after busy falls.
- ROM path is combinational in a single cycle: rom_a/rom_sel registered → ROM → output register.

## Structure
- Shared package desc_pkg holds:
  - N_DIR, WIN_ADDR_W, OFS_W;
  - the state enum {IDLE, RUN, DRAIN}.
- One natural sub-module, desc_win_cnt: an 8-bit counter with clear/enable and a terminal flag at 255.
- The ROM bank mux (36 → 1) lives outside this block.

## Test plan
- **Reset:** assert rst mid-RUN at idx 100 → all outputs 0 immediately, no done. A new start after release sweeps from idx 0.
- **Full sweep, dir=19, out_ready=1:**
  - idx 0 → dx=0x09; idx 10 → 0x1F; idx 87 → 0x02; idx 255 → 0x18.
  - Exactly 256 valid beats, out_last only at 255, done once, 258 cycles start→done.
- **Backpressure:**
  - out_ready toggling 1,0,0,1 pseudo-random → no sample lost or duplicated; idx strictly 0..255.
  - Outputs stable while stalled; final sample held in DRAIN until accepted.
- **start while busy (dir=5 at idx 40)** → ignored; rom_sel stays 19; sweep completes unchanged.
- **start with dir=36** → err pulses one cycle, busy stays 0, no out_valid.
- **Back-to-back:** start dir=0 asserted the cycle busy falls → second sweep begins; first beat idx 0 from bank 0.

Source files
------------

// File: rtl/desc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : desc_pkg
//  Description : Shared constants and FSM state type for the descriptor
//                sampling-window sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package desc_pkg;

  localparam int N_DIR      = 36;  // orientation bins / ROM banks
  localparam int WIN_ADDR_W = 8;   // 16x16 window address width
  localparam int OFS_W      = 5;   // signed ROM offset width
  localparam int DIR_W      = 6;   // orientation bin / bank select width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } win_state_t;

endpackage
`default_nettype wire

// File: rtl/desc_win_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : desc_win_cnt
//  Description : Window position counter with synchronous clear, enable and
//                a terminal flag at the last position. Saturates, never wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module desc_win_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  assign term = &cnt;

  // Count window positions; hold at the terminal value so the sweep never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/desc_win_seq.sv
`default_nettype none
// ============================================================================
//  Module      : desc_win_seq
//  Description : Walks the 256 positions of the 16x16 descriptor window,
//                addresses the external direction ROM bank and streams the
//                registered x/y offsets downstream over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module desc_win_seq #(
  parameter int N_DIR  = 36,
  parameter int ADDR_W = 8,
  parameter int OFS_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        dir,
  output logic              busy,
  output logic              err,
  output logic [5:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [OFS_W-1:0]  rom_dx,
  input  logic [OFS_W-1:0]  rom_dy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OFS_W-1:0]  out_dx,
  output logic [OFS_W-1:0]  out_dy,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              done
);

  import desc_pkg::*;

  win_state_t        state;
  logic [5:0]        sel;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_term;
  logic              load;
  logic              start_ok;
  logic              done_pend;

  // Output register may take a new sample when empty or being drained
  assign load     = (state == RUN) && (!out_valid || out_ready);
  assign start_ok = (state == IDLE) && start && (dir < 6'(N_DIR));

  // ROM is addressed straight from registers so the lookup has a full cycle
  assign rom_sel = sel;
  assign rom_a   = cnt;

  desc_win_cnt #(
    .W (ADDR_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_ok),
    .en   (load),
    .cnt  (cnt),
    .term (cnt_term)
  );

  // Sweep control FSM with registered stream outputs and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      done_pend <= 1'b0;
      out_valid <= 1'b0;
      out_dx    <= '0;
      out_dy    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      err       <= 1'b0;
      done_pend <= 1'b0;
      // done trails the final acceptance by one cycle
      done      <= done_pend;
      case (state)
        IDLE: begin
          if (start_ok) begin
            sel   <= dir;
            busy  <= 1'b1;
            state <= RUN;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        RUN: begin
          if (load) begin
            out_dx    <= rom_dx;
            out_dy    <= rom_dy;
            out_idx   <= cnt;
            out_last  <= cnt_term;
            out_valid <= 1'b1;
            if (cnt_term) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done_pend <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
